usb_hub_upstream_arbiter: RTL and testbench
===========================================

Name: usb_hub_upstream_arbiter

Overview:
- Shares the single upstream (host-facing) transmit path among NUM_USB_DEVICES downstream ports.
- Round-robin arbitration at packet granularity: a granted port owns the upstream link until end-of-packet (EOP), then an inter-packet gap is enforced.
- Supervises babble: a port that transmits longer than MAX_PKT_CYCLES is cut off and disabled until software re-enables it.
- Sits between the per-port receivers and the upstream transmitter inside the hub top level.

Parameters:
- NUM_USB_DEVICES, 1, number of downstream ports.
- IDX_W, max(1,$clog2(NUM_USB_DEVICES)), width of grant_idx.
- GAP_CYCLES, 16, idle cycles between packets, ≥1.
- MAX_PKT_CYCLES, 1024, babble limit in cycles of ownership, ≥2.

Ports:
- hi_clock  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- port_req  in  NUM_USB_DEVICES  level; port i has a packet for upstream.
- port_eop  in  NUM_USB_DEVICES  1-cycle pulse; port i finished its packet.
- port_reenable  in  NUM_USB_DEVICES  1-cycle pulse; clears port_disabled[i].
- host_busy  in  1  host is driving downstream; blocks new grants.
- grant  out  NUM_USB_DEVICES  one-hot or zero; current owner.
- grant_idx  out  IDX_W  binary index of owner; valid only while busy.
- busy  out  1  upstream owned (GRANT state).
- host_tx_en  out  1  enables the upstream driver; equals busy.
- port_disabled  out  NUM_USB_DEVICES  sticky babble-disable flags.
- babble_irq  out  1  1-cycle pulse when a port is cut off.

Behaviour:
- Reset: grant=0, grant_idx=0, busy=0, host_tx_en=0, port_disabled=0, babble_irq=0, state=IDLE, rr_ptr=0, timers=0. Reset mid-packet drops the grant on the next edge. It does not wait for EOP.
- All outputs are registered.
- eligible = port_req & ~port_disabled.
- States:
  - IDLE:
    - If host_busy=0 and eligible≠0: select the first eligible index at or after rr_ptr, wrapping modulo N.
    - Next edge: GRANT; grant/grant_idx/busy/host_tx_en set; pkt_timer=0.
    - Latency: request seen in cycle t, grant visible at t+1.
    - If host_busy=1: remain in IDLE.
  - GRANT:
    - pkt_timer increments each cycle.
    - Exit priority when several exit conditions hit in the same cycle: eop > babble > abort.
      1. port_eop[grant_idx]=1: next edge goes to GAP and clears the grant.
      2. pkt_timer==MAX_PKT_CYCLES-1 without EOP: next edge goes to GAP, clears the grant, sets port_disabled[grant_idx], and pulses babble_irq for 1 cycle.
      3. port_req[grant_idx] drops without EOP (abort): next edge goes to GAP and clears the grant.
    - On any exit, rr_ptr = (grant_idx+1) mod N.
    - port_eop from non-owner ports is ignored.
    - host_busy is ignored while in GRANT.
  - GAP:
    - gap_timer counts GAP_CYCLES cycles with all grant outputs low.
    - Then returns to IDLE.
    - The earliest regrant is visible GAP_CYCLES+1 cycles after the grant drops.
- port_disabled update:
  - Set on babble.
  - Cleared by port_reenable[i].
  - Simultaneous set and clear of the same bit: set wins.
  - port_reenable on an already-clear bit has no effect.
  - A disabled port's port_req is ignored, including in IDLE selection.
- N=1: rr_ptr and grant_idx are constant 0; behaviour is otherwise identical.
- Timer widths: $clog2(MAX_PKT_CYCLES+1) and $clog2(GAP_CYCLES+1). Timers saturate and never wrap.
- Invariants: grant is one-hot when busy=1, zero otherwise; host_tx_en==busy; grant_idx holds its last value when not busy.

Test Plan (N=4, GAP_CYCLES=4, MAX_PKT_CYCLES=64):
- Reset, then port_req=4'b0100 -> grant=4'b0100, grant_idx=2 one cycle later; pulse port_eop[2] -> grant=0 next cycle; grant stays 0 for 4 cycles; all outputs 0 during reset.
- port_req=4'b1111 held, each owner sends port_eop after 3 cycles -> grant order 0,1,2,3,0; gap of 4 cycles between each.
- port_req=4'b0010 held with no EOP for 64 cycles -> grant drops; port_disabled=4'b0010; babble_irq=1 for exactly 1 cycle; a subsequent request from port 1 is never granted; port_reenable[1] pulse -> port 1 granted after the gap.
- host_busy=1 with port_req=4'b0001 -> no grant; host_busy drops -> grant next cycle. host_busy rising during GRANT -> grant held until EOP.
- Owner drops port_req mid-packet -> grant=0 next cycle, GAP entered, rr_ptr advanced. EOP and babble limit in the same cycle -> no disable and no irq.
- reset asserted in GRANT -> grant=0 next edge; after reset release, port_req=4'b1000 -> granted one cycle later with rr_ptr starting from 0.

Source files
------------

// File: rtl/usb_hub_upstream_arbiter.sv
// Upstream transmit arbiter for a USB hub: round-robin packet-level
// ownership of the host link, inter-packet gap and babble cut-off.
module usb_hub_upstream_arbiter #(
    parameter int NUM_USB_DEVICES = 1,
    parameter int IDX_W           = (NUM_USB_DEVICES > 1) ? $clog2(NUM_USB_DEVICES) : 1,
    parameter int GAP_CYCLES      = 16,
    parameter int MAX_PKT_CYCLES  = 1024
) (
    input  logic                       hi_clock,
    input  logic                       reset,
    input  logic [NUM_USB_DEVICES-1:0] port_req,
    input  logic [NUM_USB_DEVICES-1:0] port_eop,
    input  logic [NUM_USB_DEVICES-1:0] port_reenable,
    input  logic                       host_busy,
    output logic [NUM_USB_DEVICES-1:0] grant,
    output logic [IDX_W-1:0]           grant_idx,
    output logic                       busy,
    output logic                       host_tx_en,
    output logic [NUM_USB_DEVICES-1:0] port_disabled,
    output logic                       babble_irq
);

    localparam int N     = NUM_USB_DEVICES;
    localparam int PKT_W = $clog2(MAX_PKT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(MAX_PKT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic             busy_q, busy_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PKT_W-1:0] pkt_timer_q, pkt_timer_d;
    logic [GAP_W-1:0] gap_timer_q, gap_timer_d;
    logic [N-1:0]     port_disabled_q, port_disabled_d;
    logic             babble_irq_q, babble_irq_d;

    logic [N-1:0]     eligible;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [N-1:0]     sel_onehot;
    logic             owner_req;
    logic             owner_eop;
    logic [IDX_W-1:0] next_rr;
    logic [N-1:0]     set_dis;
    logic             exit_pkt;

    function automatic int rot_idx(input int base, input int k);
        int j;
        j = base + k;
        if (j >= N) begin
            j = j - N;
        end
        return j;
    endfunction

    assign eligible  = port_req & ~port_disabled_q;
    assign owner_req = |(port_req & grant_q);
    assign owner_eop = |(port_eop & grant_q);
    assign next_rr   = (int'(grant_idx_q) == N - 1) ? '0 : grant_idx_q + IDX_W'(1);

    // First eligible port at or after rr_ptr, wrapping modulo N.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (!sel_found && eligible[rot_idx(int'(rr_ptr_q), k)]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(rot_idx(int'(rr_ptr_q), k));
            end
        end
        for (int i = 0; i < N; i++) begin
            sel_onehot[i] = (sel_idx == IDX_W'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_idx_d  = grant_idx_q;
        busy_d       = busy_q;
        rr_ptr_d     = rr_ptr_q;
        pkt_timer_d  = pkt_timer_q;
        gap_timer_d  = gap_timer_q;
        babble_irq_d = 1'b0;
        set_dis      = '0;
        exit_pkt     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                gap_timer_d = '0;
                if (!host_busy && sel_found) begin
                    state_d     = ST_GRANT;
                    grant_d     = sel_onehot;
                    grant_idx_d = sel_idx;
                    busy_d      = 1'b1;
                    pkt_timer_d = '0;
                end
            end
            ST_GRANT: begin
                if (pkt_timer_q != '1) begin
                    pkt_timer_d = pkt_timer_q + PKT_W'(1);
                end
                // EOP outranks babble, which outranks abort.
                if (owner_eop) begin
                    exit_pkt = 1'b1;
                end else if (pkt_timer_q == PKT_LAST) begin
                    exit_pkt     = 1'b1;
                    babble_irq_d = 1'b1;
                    set_dis      = grant_q;
                end else if (!owner_req) begin
                    exit_pkt = 1'b1;
                end
                if (exit_pkt) begin
                    state_d     = ST_GAP;
                    grant_d     = '0;
                    busy_d      = 1'b0;
                    gap_timer_d = '0;
                    rr_ptr_d    = next_rr;
                end
            end
            ST_GAP: begin
                if (gap_timer_q == GAP_LAST) begin
                    state_d     = ST_IDLE;
                    gap_timer_d = '0;
                end else if (gap_timer_q != '1) begin
                    gap_timer_d = gap_timer_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase

        // A babble cut-off in the same cycle as a re-enable keeps the port off.
        port_disabled_d = (port_disabled_q & ~port_reenable) | set_dis;
    end

    always_ff @(posedge hi_clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            grant_q         <= '0;
            grant_idx_q     <= '0;
            busy_q          <= 1'b0;
            rr_ptr_q        <= '0;
            pkt_timer_q     <= '0;
            gap_timer_q     <= '0;
            port_disabled_q <= '0;
            babble_irq_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            grant_idx_q     <= grant_idx_d;
            busy_q          <= busy_d;
            rr_ptr_q        <= rr_ptr_d;
            pkt_timer_q     <= pkt_timer_d;
            gap_timer_q     <= gap_timer_d;
            port_disabled_q <= port_disabled_d;
            babble_irq_q    <= babble_irq_d;
        end
    end

    assign grant         = grant_q;
    assign grant_idx     = grant_idx_q;
    assign busy          = busy_q;
    assign host_tx_en    = busy_q;
    assign port_disabled = port_disabled_q;
    assign babble_irq    = babble_irq_q;

endmodule

// File: tb/tb_usb_hub_upstream_arbiter.sv
// Directed bench for usb_hub_upstream_arbiter: vector table for the basic
// grant/gap flow, then hand sequences for round-robin, babble, busy, abort.
module tb_usb_hub_upstream_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req, eop, ren;
    logic         hb;
    logic [N-1:0] grant;
    logic [1:0]   grant_idx;
    logic         busy, host_tx_en;
    logic [N-1:0] port_disabled;
    logic         babble_irq;

    int n_chk  = 0;
    int n_fail = 0;

    usb_hub_upstream_arbiter #(
        .NUM_USB_DEVICES(4),
        .GAP_CYCLES     (4),
        .MAX_PKT_CYCLES (64)
    ) dut (
        .hi_clock     (clk),
        .reset        (rst),
        .port_req     (req),
        .port_eop     (eop),
        .port_reenable(ren),
        .host_busy    (hb),
        .grant        (grant),
        .grant_idx    (grant_idx),
        .busy         (busy),
        .host_tx_en   (host_tx_en),
        .port_disabled(port_disabled),
        .babble_irq   (babble_irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] eop;
        logic [3:0] ren;
        logic       hb;
        logic [3:0] g;
        logic [1:0] idx;
        logic [3:0] dis;
        logic       irq;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] e,
                        input logic [3:0] re, input logic h);
        req = r;
        eop = e;
        ren = re;
        hb  = h;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input string tag, input logic [3:0] g, input logic [1:0] idx,
                            input logic [3:0] dis, input logic irq, input logic ci);
        logic b;
        b = |g;
        chk({tag, ".grant"}, grant, g);
        chk({tag, ".busy"}, busy, b);
        chk({tag, ".tx_en"}, host_tx_en, b);
        if (ci || b) chk({tag, ".idx"}, grant_idx, idx);
        chk({tag, ".dis"}, port_disabled, dis);
        chk({tag, ".irq"}, babble_irq, irq);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(4'b0100, 4'b0000, 4'b0000, 1'b0);
        expect_o("rst0", 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b1);
        step(4'b0100, 4'b0100, 4'b0000, 1'b0);
        expect_o("rst1", 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b1);
        rst = 1'b0;
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        expect_o("rst2", 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};

        //             req      eop      ren     hb    grant    idx   dis     irq
        tbl[0]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 2'd2, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 4'b0000, 1'b0};
        tbl[5]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 4'b0000, 1'b0};
        tbl[6]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b0};
        tbl[7]  = '{4'b0000, 4'b0100, 4'b0000, 1'b0, 4'b0000, 2'd2, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 4'b0000, 1'b0};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 4'b0000, 1'b0};
        tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 4'b0000, 1'b0};

        rst = 1'b1;
        req = '0;
        eop = '0;
        ren = '0;
        hb  = 1'b0;
        do_reset();

        for (int v = 0; v < 12; v++) begin
            step(tbl[v].req, tbl[v].eop, tbl[v].ren, tbl[v].hb);
            expect_o($sformatf("vec%0d", v), tbl[v].g, tbl[v].idx, tbl[v].dis, tbl[v].irq, 1'b1);
        end

        // Round robin with all ports requesting.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            oh = 4'(1 << order[k]);
            step(4'b1111, 4'b0000, 4'b0000, 1'b0);
            expect_o($sformatf("rr%0d.g", k), oh, 2'(order[k]), 4'b0000, 1'b0, 1'b1);
            for (int c = 0; c < 2; c++) begin
                step(4'b1111, 4'b0000, 4'b0000, 1'b0);
                expect_o($sformatf("rr%0d.h", k), oh, 2'(order[k]), 4'b0000, 1'b0, 1'b1);
            end
            step(4'b1111, oh, 4'b0000, 1'b0);
            expect_o($sformatf("rr%0d.eop", k), 4'b0000, 2'(order[k]), 4'b0000, 1'b0, 1'b1);
            for (int c = 0; c < 4; c++) begin
                step(4'b1111, 4'b0000, 4'b0000, 1'b0);
                expect_o($sformatf("rr%0d.gap", k), 4'b0000, 2'(order[k]), 4'b0000, 1'b0, 1'b1);
            end
        end

        // Babble on port 1, with a coincident re-enable that must lose.
        step(4'b0010, 4'b0000, 4'b0000, 1'b0);
        expect_o("bab.g", 4'b0010, 2'd1, 4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 63; c++) begin
            step(4'b0010, 4'b0000, 4'b0000, 1'b0);
            expect_o("bab.hold", 4'b0010, 2'd1, 4'b0000, 1'b0, 1'b1);
        end
        step(4'b0010, 4'b0000, 4'b0010, 1'b0);
        expect_o("bab.cut", 4'b0000, 2'd1, 4'b0010, 1'b1, 1'b1);
        step(4'b0010, 4'b0000, 4'b0000, 1'b0);
        expect_o("bab.irq1", 4'b0000, 2'd1, 4'b0010, 1'b0, 1'b1);
        for (int c = 0; c < 15; c++) begin
            step(4'b0010, 4'b0000, 4'b0000, 1'b0);
            expect_o("bab.blk", 4'b0000, 2'd1, 4'b0010, 1'b0, 1'b1);
        end
        step(4'b0010, 4'b0000, 4'b0010, 1'b0);
        expect_o("bab.ren", 4'b0000, 2'd1, 4'b0000, 1'b0, 1'b1);
        step(4'b0010, 4'b0000, 4'b0000, 1'b0);
        expect_o("bab.regr", 4'b0010, 2'd1, 4'b0000, 1'b0, 1'b1);
        step(4'b0000, 4'b0010, 4'b0000, 1'b0);
        expect_o("bab.eop", 4'b0000, 2'd1, 4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) step(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // host_busy blocks new grants but not an ongoing one.
        for (int c = 0; c < 3; c++) begin
            step(4'b0001, 4'b0000, 4'b0000, 1'b1);
            expect_o("hb.blk", 4'b0000, 2'd1, 4'b0000, 1'b0, 1'b1);
        end
        step(4'b0001, 4'b0000, 4'b0000, 1'b0);
        expect_o("hb.g", 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(4'b0001, 4'b0000, 4'b0000, 1'b1);
            expect_o("hb.hold", 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1);
        end
        step(4'b0001, 4'b0010, 4'b0000, 1'b1);
        expect_o("hb.foreop", 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1);
        step(4'b0000, 4'b0001, 4'b0000, 1'b1);
        expect_o("hb.eop", 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) step(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Abort: owner drops its request; rr_ptr must move past it.
        step(4'b0100, 4'b0000, 4'b0000, 1'b0);
        expect_o("ab.g", 4'b0100, 2'd2, 4'b0000, 1'b0, 1'b1);
        step(4'b0100, 4'b0000, 4'b0000, 1'b0);
        expect_o("ab.hold", 4'b0100, 2'd2, 4'b0000, 1'b0, 1'b1);
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        expect_o("ab.drop", 4'b0000, 2'd2, 4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step(4'b0101, 4'b0000, 4'b0000, 1'b0);
            expect_o("ab.gap", 4'b0000, 2'd2, 4'b0000, 1'b0, 1'b1);
        end
        step(4'b0101, 4'b0000, 4'b0000, 1'b0);
        expect_o("ab.rr", 4'b0001, 2'd0, 4'b0000, 1'b0, 1'b1);
        step(4'b0101, 4'b0001, 4'b0000, 1'b0);
        expect_o("ab.eop", 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) step(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // EOP on the babble-limit cycle: clean exit.
        step(4'b0010, 4'b0000, 4'b0000, 1'b0);
        expect_o("eb.g", 4'b0010, 2'd1, 4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 63; c++) step(4'b0010, 4'b0000, 4'b0000, 1'b0);
        expect_o("eb.last", 4'b0010, 2'd1, 4'b0000, 1'b0, 1'b1);
        step(4'b0010, 4'b0010, 4'b0000, 1'b0);
        expect_o("eb.eop", 4'b0000, 2'd1, 4'b0000, 1'b0, 1'b1);
        step(4'b0010, 4'b0000, 4'b0000, 1'b0);
        expect_o("eb.after", 4'b0000, 2'd1, 4'b0000, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) step(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Reset while granted.
        step(4'b0100, 4'b0000, 4'b0000, 1'b0);
        expect_o("rg.g", 4'b0100, 2'd2, 4'b0000, 1'b0, 1'b1);
        rst = 1'b1;
        step(4'b0100, 4'b0000, 4'b0000, 1'b0);
        expect_o("rg.rst", 4'b0000, 2'd0, 4'b0000, 1'b0, 1'b1);
        rst = 1'b0;
        step(4'b1000, 4'b0000, 4'b0000, 1'b0);
        expect_o("rg.regr", 4'b1000, 2'd3, 4'b0000, 1'b0, 1'b1);
        step(4'b0000, 4'b1000, 4'b0000, 1'b0);
        expect_o("rg.eop", 4'b0000, 2'd3, 4'b0000, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
